// File: rtl/camera_controller_if.sv
// Signal bundle between the camera controller and its neighbours: the
// debounced user inputs (init, exposure buttons) and the strobes to the
// analogue pixel array / ADC block.
//   master : user/button side, drives the requests and observes the strobes
//   slave  : the camera controller itself
interface camera_controller_if;
  logic init;
  logic exp_increase;
  logic exp_decrease;
  logic NRE_1;
  logic NRE_2;
  logic ADC;
  logic expose;
  logic erase;

  modport master (
    output init, exp_increase, exp_decrease,
    input  NRE_1, NRE_2, ADC, expose, erase
  );

  modport slave (
    input  init, exp_increase, exp_decrease,
    output NRE_1, NRE_2, ADC, expose, erase
  );
endinterface

// File: rtl/camera_controller.sv
// camera_controller: sequences erase -> exposure -> two-row readout for a
// 2x2 pixel array and holds a button-adjustable exposure time (2..30 cycles).
// All strobes are registered Moore outputs of the current state, so they
// appear one edge after the state is entered.
//
// Optional feature: define CAMERA_CTRL_INIT_EDGE_EN to make init rising-edge
// triggered (a held init never retriggers, including straight after reset).
// Without it init is level-sensitive and a held init repeats sequences.
module camera_controller (
  input  logic                 clk,
  input  logic                 rst,
  camera_controller_if.slave   cam
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXPOSURE = 2'd1,
    READOUT  = 2'd2
  } state_t;

  localparam logic [4:0] EXP_MIN = 5'd2;
  localparam logic [4:0] EXP_MAX = 5'd30;
  localparam logic [2:0] K_LAST  = 3'd5;

  state_t     state, state_d;
  logic [4:0] cnt, cnt_d;
  logic [2:0] k, k_d;
  logic [4:0] exp_time, exp_time_d;
  logic       start;

  logic nre_1_d, nre_2_d, adc_d, expose_d, erase_d;

`ifdef CAMERA_CTRL_INIT_EDGE_EN
  logic init_q;

  // Previous init level; reset high so an init held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) init_q <= 1'b1;
    else     init_q <= cam.init;
  end

  assign start = cam.init & ~init_q;
`else
  assign start = cam.init;
`endif

  // State, counters and exposure setting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      k        <= 3'd0;
      exp_time <= EXP_MIN;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      k        <= k_d;
      exp_time <= exp_time_d;
    end
  end

  // Next-state logic; exp_time only moves in IDLE and a start request wins over buttons.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    k_d        = k;
    exp_time_d = exp_time;
    case (state)
      IDLE: begin
        cnt_d = 5'd0;
        k_d   = 3'd0;
        if (start) begin
          state_d = EXPOSURE;
        end else if (cam.exp_increase && !cam.exp_decrease) begin
          if (exp_time != EXP_MAX) exp_time_d = exp_time + 5'd1;
        end else if (cam.exp_decrease && !cam.exp_increase) begin
          if (exp_time != EXP_MIN) exp_time_d = exp_time - 5'd1;
        end
      end
      EXPOSURE: begin
        // cnt runs 0..exp_time-1, giving exactly exp_time cycles in this state.
        if (cnt == exp_time - 5'd1) begin
          state_d = READOUT;
          cnt_d   = 5'd0;
          k_d     = 3'd0;
        end else begin
          cnt_d = cnt + 5'd1;
        end
      end
      READOUT: begin
        if (k == K_LAST) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else begin
          k_d = k + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        k_d     = 3'd0;
      end
    endcase
  end

  // Strobe decode from the current state; the readout slots keep the two
  // NRE lines mutually exclusive and put ADC only inside a single NRE window.
  always_comb begin
    nre_1_d  = 1'b1;
    nre_2_d  = 1'b1;
    adc_d    = 1'b0;
    expose_d = 1'b0;
    erase_d  = 1'b0;
    case (state)
      IDLE:     erase_d  = 1'b1;
      EXPOSURE: expose_d = 1'b1;
      READOUT: begin
        case (k)
          3'd0: nre_1_d = 1'b0;
          3'd1: begin nre_1_d = 1'b0; adc_d = 1'b1; end
          3'd3: nre_2_d = 1'b0;
          3'd4: begin nre_2_d = 1'b0; adc_d = 1'b1; end
          default: ;
        endcase
      end
      default: erase_d = 1'b1;
    endcase
  end

  // Output registers; reset forces the idle pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      cam.NRE_1  <= 1'b1;
      cam.NRE_2  <= 1'b1;
      cam.ADC    <= 1'b0;
      cam.expose <= 1'b0;
      cam.erase  <= 1'b1;
    end else begin
      cam.NRE_1  <= nre_1_d;
      cam.NRE_2  <= nre_2_d;
      cam.ADC    <= adc_d;
      cam.expose <= expose_d;
      cam.erase  <= erase_d;
    end
  end

endmodule

// File: tb/tb_camera_controller.sv
// Directed bench for camera_controller: reset, default exposure, exposure
// saturation both ways, reset mid-exposure, and held-init behaviour.
module tb_camera_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  camera_controller_if cam();

  camera_controller dut (
    .clk (clk),
    .rst (rst),
    .cam (cam)
  );

  always #5 clk = ~clk;

  // {NRE_1, NRE_2, ADC, expose, erase}
  localparam logic [4:0] P_IDLE = 5'b11001;

  function automatic logic [4:0] outs();
    return {cam.NRE_1, cam.NRE_2, cam.ADC, cam.expose, cam.erase};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic inc, input logic dec, input int n);
    cam.exp_increase = inc;
    cam.exp_decrease = dec;
    repeat (n) step();
    cam.exp_increase = 1'b0;
    cam.exp_decrease = 1'b0;
  endtask

  // One init pulse; measures the expose window then checks the readout slots.
  task automatic do_seq(input string tag, input int exp_len, input logic hold_inc);
    logic [4:0] pat [0:5];
    int n;
    pat[0] = 5'b01000;
    pat[1] = 5'b01100;
    pat[2] = 5'b11000;
    pat[3] = 5'b10000;
    pat[4] = 5'b10100;
    pat[5] = 5'b11000;
    cam.init = 1'b1;
    step();
    cam.init = 1'b0;
    cam.exp_increase = hold_inc;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (cam.expose !== 1'b1) break;
      n++;
    end
    chk($sformatf("%s expose_len", tag), n, exp_len);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) step();
      chk($sformatf("%s readout_k%0d", tag, j), int'(outs()), int'(pat[j]));
    end
    cam.exp_increase = 1'b0;
    step();
    chk($sformatf("%s back_idle", tag), int'(outs()), int'(P_IDLE));
  endtask

  // Hold init for hold_n cycles, then count expose rising edges.
  task automatic held_init(input string tag, input int hold_n, input int exp_rises);
    int   rises;
    logic prev;
    rises = 0;
    prev  = cam.expose;
    cam.init = 1'b1;
    for (int i = 0; i < hold_n + 20; i++) begin
      if (i == hold_n) cam.init = 1'b0;
      step();
      if (cam.expose === 1'b1 && prev !== 1'b1) rises++;
      prev = cam.expose;
    end
    cam.init = 1'b0;
    chk($sformatf("%s seq_count", tag), rises, exp_rises);
    chk($sformatf("%s final_idle", tag), int'(outs()), int'(P_IDLE));
  endtask

  initial begin
    cam.init         = 1'b0;
    cam.exp_increase = 1'b0;
    cam.exp_decrease = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset outs", int'(outs()), int'(P_IDLE));
    chk("reset exp_time", int'(dut.exp_time), 2);
    rst = 1'b0;
    step();
    chk("idle after reset", int'(outs()), int'(P_IDLE));

    // Default exposure of 2 cycles.
    do_seq("default", 2, 1'b0);

    // Ramp up, with both buttons overlapped mid-ramp, then saturate at 30.
    press(1'b1, 1'b0, 20);
    chk("inc ramp", int'(dut.exp_time), 22);
    press(1'b1, 1'b1, 3);
    chk("inc+dec hold", int'(dut.exp_time), 22);
    press(1'b1, 1'b0, 17);
    chk("inc saturate", int'(dut.exp_time), 30);
    do_seq("exp30", 30, 1'b0);

    // Down to 10, then saturate at 2.
    press(1'b0, 1'b1, 20);
    chk("dec to 10", int'(dut.exp_time), 10);
    press(1'b0, 1'b1, 16);
    chk("dec saturate", int'(dut.exp_time), 2);
    do_seq("exp2", 2, 1'b0);

    // Reset on the 5th expose cycle with a button held during exposure.
    press(1'b1, 1'b0, 13);
    chk("set 15", int'(dut.exp_time), 15);
    cam.init = 1'b1;
    step();
    cam.init = 1'b0;
    cam.exp_increase = 1'b1;
    repeat (5) step();
    chk("mid expose", int'(cam.expose), 1);
    chk("btn ignored exposing", int'(dut.exp_time), 15);
    rst = 1'b1;
    cam.exp_increase = 1'b0;
    step();
    chk("mid rst outs", int'(outs()), int'(P_IDLE));
    chk("mid rst exp_time", int'(dut.exp_time), 2);
    rst = 1'b0;
    step();
    chk("post rst idle", int'(outs()), int'(P_IDLE));

    // Button held throughout exposure and readout must not change exp_time.
    do_seq("btn_in_seq", 2, 1'b1);
    chk("btn ignored in seq", int'(dut.exp_time), 2);

`ifdef CAMERA_CTRL_INIT_EDGE_EN
    held_init("held_edge", 40, 1);
    // init held high across reset must not start a sequence.
    cam.init = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    held_init("held_through_rst", 12, 0);
`else
    // Sequences start at edges 0, 9, 18, 27, 36 of the 40 held cycles.
    held_init("held_level", 40, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
